// File: rtl/data_ram_pkg.sv
// Shared definitions for the data RAM responder.
//   state_e        : responder FSM encoding
//   PoisonWord     : read data returned for an out-of-range access (range-check build)
//   DefaultDepth   : default number of words
//   DefaultLatency : default request-to-operation latency
//   CntW           : counter width, enough for a latency of 1..15
package data_ram_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StResp    = 2'd2,
    StRelease = 2'd3
  } state_e;

  localparam logic [31:0] PoisonWord     = 32'hDEAD_BEEF;
  localparam int unsigned DefaultDepth   = 256;
  localparam int unsigned DefaultLatency = 2;
  localparam int unsigned CntW           = 4;

endpackage

// File: rtl/data_ram_responder_if.sv
// Data-memory request/response bundle between the requester and the RAM responder.
//   memory_addr/rden/wren/write_val : request (requester -> responder)
//   memory_read_val/response/busy   : completion (responder -> requester)
//   memory_error                    : out-of-range flag, only with DATA_RAM_RANGE_CHECK_EN
// Modports: master (requester side), slave (responder side).
interface data_ram_responder_if #(
  parameter int unsigned S = 32
);
  logic [31:0]  memory_addr;
  logic         memory_rden;
  logic         memory_wren;
  logic [S-1:0] memory_write_val;
  logic [S-1:0] memory_read_val;
  logic         memory_response;
  logic         busy;
`ifdef DATA_RAM_RANGE_CHECK_EN
  logic         memory_error;

  modport master (
    output memory_addr, memory_rden, memory_wren, memory_write_val,
    input  memory_read_val, memory_response, busy, memory_error
  );
  modport slave (
    input  memory_addr, memory_rden, memory_wren, memory_write_val,
    output memory_read_val, memory_response, busy, memory_error
  );
`else
  modport master (
    output memory_addr, memory_rden, memory_wren, memory_write_val,
    input  memory_read_val, memory_response, busy
  );
  modport slave (
    input  memory_addr, memory_rden, memory_wren, memory_write_val,
    output memory_read_val, memory_response, busy
  );
`endif
endinterface

// File: rtl/data_ram_array.sv
// Synchronous single-port S x DEPTH storage.
//   clk  : clock
//   we   : write enable
//   addr : word index
//   din  : write data
//   dout : registered read data; read-before-write, so a write cycle returns the old word
// Contents have no reset.
module data_ram_array #(
  parameter int unsigned S     = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [S-1:0]  din,
  output logic [S-1:0]  dout
);

  logic [S-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/data_ram_responder.sv
// Backing store for the data-memory request interface. One request at a time: it is accepted
// in idle, the operation happens LATENCY cycles later, memory_response then pulses once, and
// busy drops once the requester has released rden/wren.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : data_ram_responder_if slave modport
// Optional feature: define DATA_RAM_RANGE_CHECK_EN to add memory_error, suppress out-of-range
// writes and return a poison word for out-of-range reads. Otherwise high address bits alias.
module data_ram_responder
  import data_ram_pkg::*;
#(
  parameter int unsigned S       = 32,
  parameter int unsigned DEPTH   = DefaultDepth,
  parameter int unsigned LATENCY = DefaultLatency
) (
  input  logic                 clk,
  input  logic                 reset,
  data_ram_responder_if.slave  bus
);

  localparam int unsigned IW      = $clog2(DEPTH);
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [IW-1:0]   idx_q;
  logic            rd_q;
  logic            wr_q;
  logic [S-1:0]    wval_q;
  logic [S-1:0]    arr_dout;
  logic            arr_we;
  logic            err;

`ifdef DATA_RAM_RANGE_CHECK_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Operation fires on the last WAIT cycle; reset gating drops a write caught by reset.
  assign arr_we = (state == StWait) && (cnt == '0) && wr_q && !err && !reset;

  data_ram_array #(
    .S     (S),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (idx_q),
    .din  (wval_q),
    .dout (arr_dout)
  );

  // Outputs are registered: the RESP state loads response/read_val, so the pulse is
  // visible in the cycle after RESP, i.e. LATENCY+1 edges after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= StIdle;
      cnt                 <= '0;
      bus.memory_read_val <= '0;
      bus.memory_response <= 1'b0;
      bus.busy            <= 1'b0;
`ifdef DATA_RAM_RANGE_CHECK_EN
      bus.memory_error    <= 1'b0;
      err_q               <= 1'b0;
`endif
    end else begin
      bus.memory_response <= 1'b0;
`ifdef DATA_RAM_RANGE_CHECK_EN
      bus.memory_error    <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (bus.memory_rden || bus.memory_wren) begin
            idx_q    <= bus.memory_addr[IW-1:0];
            rd_q     <= bus.memory_rden;
            wr_q     <= bus.memory_wren;
            wval_q   <= bus.memory_write_val;
`ifdef DATA_RAM_RANGE_CHECK_EN
            err_q    <= (bus.memory_addr >= 32'(DEPTH));
`endif
            bus.busy <= 1'b1;
            cnt      <= CntInit;
            state    <= StWait;
          end
        end
        StWait: begin
          if (cnt == '0) begin
            state <= StResp;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StResp: begin
          bus.memory_response <= 1'b1;
`ifdef DATA_RAM_RANGE_CHECK_EN
          bus.memory_error    <= err_q;
`endif
          // read_val only changes for reads; a plain write leaves the last read data.
          if (rd_q) begin
            bus.memory_read_val <= err ? S'(PoisonWord) : arr_dout;
          end
          state <= StRelease;
        end
        StRelease: begin
          // Wait for the requester to drop its level so a held request cannot retrigger.
          if (!bus.memory_rden && !bus.memory_wren) begin
            bus.busy <= 1'b0;
            state    <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_ram_responder_if #(.S(32)) b0 ();
  data_ram_responder_if #(.S(32)) b1 ();
  data_ram_responder_if #(.S(32)) b15 ();

  data_ram_responder #(.S(32), .DEPTH(256), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );
  data_ram_responder #(.S(32), .DEPTH(256), .LATENCY(1)) dut_l1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );
  data_ram_responder #(.S(32), .DEPTH(256), .LATENCY(15)) dut_l15 (
    .clk   (clk),
    .reset (reset),
    .bus   (b15)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic get_err();
`ifdef DATA_RAM_RANGE_CHECK_EN
    return b0.memory_error;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one request on b0, hold it one cycle past the response, then release.
  // lat: edges from the first edge seeing the request to the response being visible.
  task automatic txn(input logic [31:0] a, input logic rd, input logic wr,
                     input logic [31:0] wv, output int lat, output logic [31:0] rv,
                     output logic er, output int pulses, output int rel);
    @(posedge clk); #1;
    b0.memory_addr = a; b0.memory_rden = rd; b0.memory_wren = wr; b0.memory_write_val = wv;
    lat = -1; pulses = 0; rv = 'x; er = 1'bx; rel = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (b0.memory_response) begin
        pulses++;
        if (lat < 0) begin
          lat = i; rv = b0.memory_read_val; er = get_err();
        end
      end
      if (lat >= 0 && i > lat) break;
    end
    b0.memory_rden = 1'b0; b0.memory_wren = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (!b0.busy) begin
        rel = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (b0.memory_read_val !== 32'h0 || b0.memory_response !== 1'b0 || b0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: read_val=%h resp=%b busy=%b, required 0/0/0",
               b0.memory_read_val, b0.memory_response, b0.busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    int lat, pulses, rel; logic [31:0] rv; logic er;
    txn(32'd5, 1'b0, 1'b1, 32'h1234_5678, lat, rv, er, pulses, rel);
    n_cmp++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL wr_latency: got %0d, required 3", lat);
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL wr_pulses: got %0d, required 1", pulses);
    end
    n_cmp++;
    if (rv !== 32'h0) begin
      n_fail++; $display("FAIL wr_keeps_read_val: got %h, required 00000000", rv);
    end
    n_cmp++;
    if (rel !== 1) begin
      n_fail++; $display("FAIL wr_release: got %0d, required 1", rel);
    end
    txn(32'd5, 1'b1, 1'b0, 32'h0, lat, rv, er, pulses, rel);
    n_cmp++;
    if (rv !== 32'h1234_5678) begin
      n_fail++; $display("FAIL rd_data: got %h, required 12345678", rv);
    end
    n_cmp++;
    if (lat !== 3 || pulses !== 1) begin
      n_fail++; $display("FAIL rd_timing: lat %0d pulses %0d, required 3 1", lat, pulses);
    end
  endtask

  task automatic test_hold();
    int lat = -1;
    int pulses = 0;
    bit busy_ok = 1'b1;
    @(posedge clk); #1;
    b0.memory_addr = 32'd5; b0.memory_rden = 1'b1; b0.memory_wren = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (b0.memory_response) begin
        pulses++; lat = i; break;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (b0.memory_response) pulses++;
      if (b0.busy !== 1'b1) busy_ok = 1'b0;
    end
    n_cmp++;
    if (pulses !== 1 || lat !== 3) begin
      n_fail++; $display("FAIL hold_pulses: pulses %0d lat %0d, required 1 3", pulses, lat);
    end
    n_cmp++;
    if (!busy_ok) begin
      n_fail++; $display("FAIL hold_busy: busy dropped while held, required 1");
    end
    b0.memory_rden = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (b0.busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: busy=%b, required 0", b0.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, pulses, rel; logic [31:0] rv; logic er;
    int late = 0;
    txn(32'd7, 1'b0, 1'b1, 32'h0000_0077, lat, rv, er, pulses, rel);
    @(posedge clk); #1;
    b0.memory_addr = 32'd7; b0.memory_wren = 1'b1; b0.memory_write_val = 32'h0000_0BAD;
    @(posedge clk); #1;
    n_cmp++;
    if (b0.busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_accept_busy: got %b, required 1", b0.busy);
    end
    reset = 1'b1; b0.memory_wren = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (b0.busy !== 1'b0 || b0.memory_response !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_op: busy=%b resp=%b, required 0 0", b0.busy, b0.memory_response);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (b0.memory_response) late++;
    end
    n_cmp++;
    if (late !== 0) begin
      n_fail++; $display("FAIL rst_no_resp: got %0d pulses, required 0", late);
    end
    txn(32'd7, 1'b1, 1'b0, 32'h0, lat, rv, er, pulses, rel);
    n_cmp++;
    if (rv !== 32'h0000_0077) begin
      n_fail++; $display("FAIL rst_write_dropped: got %h, required 00000077", rv);
    end
  endtask

  task automatic test_rd_wr_same();
    int lat, pulses, rel; logic [31:0] rv; logic er;
    txn(32'd3, 1'b0, 1'b1, 32'hA, lat, rv, er, pulses, rel);
    txn(32'd3, 1'b1, 1'b1, 32'hB, lat, rv, er, pulses, rel);
    n_cmp++;
    if (rv !== 32'hA) begin
      n_fail++; $display("FAIL rdwr_old_value: got %h, required 0000000a", rv);
    end
    txn(32'd3, 1'b1, 1'b0, 32'h0, lat, rv, er, pulses, rel);
    n_cmp++;
    if (rv !== 32'hB) begin
      n_fail++; $display("FAIL rdwr_new_value: got %h, required 0000000b", rv);
    end
  endtask

  task automatic test_range();
    int lat, pulses, rel; logic [31:0] rv; logic er;
    txn(32'd44, 1'b0, 1'b1, 32'h0000_0044, lat, rv, er, pulses, rel);
    txn(32'd300, 1'b1, 1'b0, 32'h0, lat, rv, er, pulses, rel);
`ifdef DATA_RAM_RANGE_CHECK_EN
    n_cmp++;
    if (rv !== 32'hDEAD_BEEF || er !== 1'b1) begin
      n_fail++; $display("FAIL range_error: data %h err %b, required deadbeef 1", rv, er);
    end
`else
    n_cmp++;
    if (rv !== 32'h0000_0044) begin
      n_fail++; $display("FAIL range_alias: got %h, required 00000044", rv);
    end
`endif
    txn(32'd44, 1'b1, 1'b0, 32'h0, lat, rv, er, pulses, rel);
    n_cmp++;
    if (rv !== 32'h0000_0044 || er !== 1'b0) begin
      n_fail++; $display("FAIL range_in_bounds: data %h err %b, required 00000044 0", rv, er);
    end
  endtask

  task automatic test_latency();
    int lat1 = -1;
    int lat15 = -1;
    @(posedge clk); #1;
    b1.memory_addr = 32'd1; b1.memory_rden = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (b1.memory_response) begin
        lat1 = i; break;
      end
    end
    b1.memory_rden = 1'b0;
    n_cmp++;
    if (lat1 !== 2) begin
      n_fail++; $display("FAIL latency_1: got %0d, required 2", lat1);
    end
    @(posedge clk); #1;
    b15.memory_addr = 32'd1; b15.memory_rden = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (b15.memory_response) begin
        lat15 = i; break;
      end
    end
    b15.memory_rden = 1'b0;
    n_cmp++;
    if (lat15 !== 16) begin
      n_fail++; $display("FAIL latency_15: got %0d, required 16", lat15);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1;
    b0.memory_addr = '0;  b0.memory_rden = 1'b0;  b0.memory_wren = 1'b0;  b0.memory_write_val = '0;
    b1.memory_addr = '0;  b1.memory_rden = 1'b0;  b1.memory_wren = 1'b0;  b1.memory_write_val = '0;
    b15.memory_addr = '0; b15.memory_rden = 1'b0; b15.memory_wren = 1'b0; b15.memory_write_val = '0;
    test_reset();
    test_write_read();
    test_hold();
    test_reset_mid_op();
    test_rd_wr_same();
    test_range();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
